// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the fetch stage; decode and hazard logic import the same types.
package instr_fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or replace it with a bubble.
module if_id_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid
);

  // bubble wins over load; id_pc is kept through a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc    <= 32'h0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (bubble) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (load) begin
      id_pc    <= pc_in;
      id_instr <= instr_in;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, redirect handling, fault trapping and fetch counter.
//   state | meaning
//   RUN   | fetching, honouring redirect and stall
//   FAULT | misaligned redirect or out-of-range PC; frozen until rst
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // 33-bit limit so a full 4 GiB memory does not overflow the compare
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) << 2;

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         fault_q;
  logic [31:0]  count_q;
  logic         run;
  logic         in_range;
  logic         misaligned;
  logic         load;
  logic         bubble;

  always_comb begin
    run        = (state_q == RUN);
    in_range   = ({1'b0, pc_q} < IMEM_LIMIT);
    misaligned = (redirect_pc[1:0] != 2'b00);
    load       = run && !redirect && !stall && in_range;
    bubble     = !run || redirect || (!stall && !in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect) begin
            if (misaligned) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q <= redirect_pc;
            end
          end else if (!stall) begin
            if (in_range) begin
              pc_q    <= pc_q + 32'd4;
              count_q <= count_q + 32'd1;
            end else begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        FAULT: begin
          state_q <= FAULT;
          fault_q <= 1'b1;
        end
        default: begin
          state_q <= FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .bubble  (bubble),
    .pc_in   (pc_q),
    .instr_in(imem_instr),
    .id_pc   (id_pc),
    .id_instr(id_instr),
    .id_valid(id_valid)
  );

  assign imem_addr   = pc_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scenario bench for instr_fetch: expected IF/ID contents are queued on stimulus and checked after each edge.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr, imem_instr, id_pc, id_instr, fetch_count;
  logic        id_valid, fault;

  logic        rst4 = 1'b1, stall4 = 1'b0, redirect4 = 1'b0;
  logic [31:0] redirect_pc4 = 32'h0;
  logic [31:0] imem_addr4, imem_instr4, id_pc4, id_instr4, fetch_count4;
  logic        id_valid4, fault4;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0140_0313;
      32'h4:   return 32'h01e0_0393;
      default: return 32'hA500_0000 ^ a;
    endcase
  endfunction

  assign imem_instr  = mem_word(imem_addr);
  assign imem_instr4 = mem_word(imem_addr4);

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .id_pc(id_pc), .id_instr(id_instr),
    .id_valid(id_valid), .fault(fault), .fetch_count(fetch_count)
  );

  instr_fetch #(.IMEM_WORDS(4)) dut4 (
    .clk(clk), .rst(rst4), .stall(stall4), .redirect(redirect4), .redirect_pc(redirect_pc4),
    .imem_addr(imem_addr4), .imem_instr(imem_instr4), .id_pc(id_pc4), .id_instr(id_instr4),
    .id_valid(id_valid4), .fault(fault4), .fetch_count(fetch_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sb.push_back('{pc: 32'h0, instr: NOP, valid: 1'b0});
    tick();
    tick();
    e = sb.pop_front();
    total++;
    if ({id_pc, id_instr, id_valid} !== e) begin
      bad++;
      $display("FAIL reset_ifid got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
               id_pc, id_instr, id_valid, e.pc, e.instr, e.valid);
    end
    total++;
    if ({imem_addr, fault, fetch_count} !== {32'h0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_state got addr=%h fault=%b cnt=%0d want 0/0/0", imem_addr, fault, fetch_count);
    end
  endtask

  task automatic test_fetch();
    rst = 1'b0;
    total++;
    if (imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL first_addr got %h want 00000000", imem_addr);
    end
    sb.push_back('{pc: 32'h0, instr: 32'h0140_0313, valid: 1'b1});
    sb.push_back('{pc: 32'h4, instr: 32'h01e0_0393, valid: 1'b1});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if ({id_pc, id_instr, id_valid} !== e) begin
        bad++;
        $display("FAIL fetch%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                 i, id_pc, id_instr, id_valid, e.pc, e.instr, e.valid);
      end
    end
    total++;
    if (fetch_count !== 32'd2) begin
      bad++;
      $display("FAIL fetch_count got %0d want 2", fetch_count);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{pc: 32'h4, instr: 32'h01e0_0393, valid: 1'b1});
      tick();
      e = sb.pop_front();
      total++;
      if ({id_pc, id_instr, id_valid, imem_addr, fetch_count} !== {e, 32'h8, 32'd2}) begin
        bad++;
        $display("FAIL stall%0d got pc=%h instr=%h v=%b addr=%h cnt=%0d want pc=%h addr=8 cnt=2",
                 i, id_pc, id_instr, id_valid, imem_addr, fetch_count, e.pc);
      end
    end
    stall = 1'b0;
    sb.push_back('{pc: 32'h8, instr: mem_word(32'h8), valid: 1'b1});
    tick();
    e = sb.pop_front();
    total++;
    if ({id_pc, id_instr, id_valid, fetch_count} !== {e, 32'd3}) begin
      bad++;
      $display("FAIL stall_resume got pc=%h instr=%h v=%b cnt=%0d want pc=%h instr=%h cnt=3",
               id_pc, id_instr, id_valid, fetch_count, e.pc, e.instr);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h10; stall = 1'b1;
    sb.push_back('{pc: 32'h8, instr: NOP, valid: 1'b0});
    tick();
    redirect = 1'b0; stall = 1'b0;
    e = sb.pop_front();
    total++;
    if ({id_pc, id_instr, id_valid, imem_addr} !== {e, 32'h10}) begin
      bad++;
      $display("FAIL redirect_bubble got pc=%h instr=%h v=%b addr=%h want pc=%h instr=%h v=0 addr=10",
               id_pc, id_instr, id_valid, imem_addr, e.pc, e.instr);
    end
    sb.push_back('{pc: 32'h10, instr: mem_word(32'h10), valid: 1'b1});
    tick();
    e = sb.pop_front();
    total++;
    if ({id_pc, id_instr, id_valid, fetch_count} !== {e, 32'd4}) begin
      bad++;
      $display("FAIL redirect_target got pc=%h instr=%h v=%b cnt=%0d want pc=%h cnt=4",
               id_pc, id_instr, id_valid, fetch_count, e.pc);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) sb.push_back('{pc: 32'h14 + 4*i, instr: mem_word(32'h14 + 4*i), valid: 1'b1});
    sb.push_back('{pc: 32'h1c, instr: NOP, valid: 1'b0});
    sb.push_back('{pc: 32'h1c, instr: NOP, valid: 1'b0});
    sb.push_back('{pc: 32'h80, instr: mem_word(32'h80), valid: 1'b1});
    for (int i = 0; i < 6; i++) begin
      redirect    = (i == 3 || i == 4);
      redirect_pc = (i == 3) ? 32'h40 : 32'h80;
      tick();
      e = sb.pop_front();
      total++;
      if ({id_pc, id_instr, id_valid} !== e) begin
        bad++;
        $display("FAIL b2b%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                 i, id_pc, id_instr, id_valid, e.pc, e.instr, e.valid);
      end
    end
    redirect = 1'b0;
    total++;
    if ({imem_addr, fetch_count} !== {32'h84, 32'd8}) begin
      bad++;
      $display("FAIL b2b_state got addr=%h cnt=%0d want 84/8", imem_addr, fetch_count);
    end
  endtask

  task automatic test_fault();
    redirect = 1'b1; redirect_pc = 32'h12;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{pc: 32'h80, instr: NOP, valid: 1'b0});
      tick();
      redirect_pc = 32'h40; stall = i[0]; redirect = ~i[0];
      e = sb.pop_front();
      total++;
      if ({id_pc, id_instr, id_valid, fault, imem_addr, fetch_count} !== {e, 1'b1, 32'h84, 32'd8}) begin
        bad++;
        $display("FAIL fault%0d got pc=%h v=%b fault=%b addr=%h cnt=%0d want pc=%h v=0 fault=1 addr=84 cnt=8",
                 i, id_pc, id_valid, fault, imem_addr, fetch_count, e.pc);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    total++;
    if ({imem_addr, fault, id_valid, fetch_count} !== {32'h0, 1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL fault_clear got addr=%h fault=%b v=%b cnt=%0d want 0/0/0/0",
               imem_addr, fault, id_valid, fetch_count);
    end
  endtask

  task automatic test_rst_during_stall();
    repeat (8) tick();
    total++;
    if ({imem_addr, fetch_count} !== {32'h20, 32'd8}) begin
      bad++;
      $display("FAIL pre_stall got addr=%h cnt=%0d want 20/8", imem_addr, fetch_count);
    end
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({imem_addr, id_valid, fetch_count, id_pc} !== {32'h0, 1'b0, 32'd0, 32'h0}) begin
      bad++;
      $display("FAIL rst_stall got addr=%h v=%b cnt=%0d pc=%h want 0/0/0/0",
               imem_addr, id_valid, fetch_count, id_pc);
    end
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_range();
    rst4 = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back('{pc: 4*i, instr: mem_word(4*i), valid: 1'b1});
    sb.push_back('{pc: 32'hc, instr: NOP, valid: 1'b0});
    sb.push_back('{pc: 32'hc, instr: NOP, valid: 1'b0});
    for (int i = 0; i < 6; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if ({id_pc4, id_instr4, id_valid4} !== e) begin
        bad++;
        $display("FAIL range%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                 i, id_pc4, id_instr4, id_valid4, e.pc, e.instr, e.valid);
      end
    end
    total++;
    if ({fault4, imem_addr4, fetch_count4} !== {1'b1, 32'h10, 32'd4}) begin
      bad++;
      $display("FAIL range_fault got fault=%b addr=%h cnt=%0d want 1/10/4", fault4, imem_addr4, fetch_count4);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_fault();
    test_rst_during_stall();
    test_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
